// File: rtl/phy_rx_pkg.sv
// Shared definitions for the PHY receive link-synchronisation controller.
package phy_rx_pkg;

  typedef enum logic [2:0] {
    ST_HUNT      = 3'd0,
    ST_SLIP_WAIT = 3'd1,
    ST_LOCK      = 3'd2,
    ST_ACTIVE    = 3'd3
  } state_e;

  localparam logic [7:0]  COMMA_DEFAULT      = 8'hBC;
  localparam int unsigned LOCK_COUNT_DEFAULT = 4;

endpackage

// File: rtl/phy_rx_sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module phy_rx_sat_counter #(
  parameter int unsigned MAX = 15,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Hunt/slip/lock byte-alignment FSM on comma symbols; gates payload to the
// upper layer once synchronised and drops sync on repeated symbol errors.
module phy_rx_sync_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0]  COMMA        = COMMA_DEFAULT,
  parameter int unsigned LOCK_COUNT   = LOCK_COUNT_DEFAULT,
  parameter int unsigned SLIP_TIMEOUT = 16,
  parameter int unsigned SLIP_SETTLE  = 8,
  parameter int unsigned ERR_LIMIT    = 3
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  input  logic       sym_err,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       slip_req,
  output logic [3:0] bc_counter,
  output logic [2:0] state_out
);

  localparam int unsigned HUNT_W   = $clog2(SLIP_TIMEOUT + 1);
  localparam int unsigned SETTLE_W = $clog2(SLIP_SETTLE + 1);
  localparam int unsigned BC_W     = $clog2(LOCK_COUNT + 1);
  localparam int unsigned ERR_W    = $clog2(ERR_LIMIT + 1);

  // Transitions fire on the event that would take a counter to its limit,
  // so each comparison is against limit-1.
  localparam logic [HUNT_W-1:0]   HUNT_LAST   = HUNT_W'(SLIP_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE - 1);
  localparam logic [BC_W-1:0]     BC_LAST     = BC_W'(LOCK_COUNT - 1);
  localparam logic [ERR_W-1:0]    ERR_LAST    = ERR_W'(ERR_LIMIT - 1);

  state_e     state_q, state_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_out_q, valid_out_d;
  logic       slip_req_q, slip_req_d;

  logic hunt_clr, hunt_en, settle_clr, settle_en;
  logic bc_clr, bc_en, err_clr, err_en;

  logic [HUNT_W-1:0]   hunt_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [BC_W-1:0]     bc_cnt;
  logic [ERR_W-1:0]    err_cnt;

  logic is_comma, is_other;

  assign is_comma = data_in_valid && !sym_err && (data_in == COMMA);
  assign is_other = data_in_valid && !is_comma;

  phy_rx_sat_counter #(.MAX(SLIP_TIMEOUT), .W(HUNT_W)) u_hunt_timer (
    .clk_i (clk_f), .rst_ni(reset), .clr_i(hunt_clr), .en_i(hunt_en), .cnt_o(hunt_cnt)
  );

  phy_rx_sat_counter #(.MAX(SLIP_SETTLE), .W(SETTLE_W)) u_settle_timer (
    .clk_i (clk_f), .rst_ni(reset), .clr_i(settle_clr), .en_i(settle_en), .cnt_o(settle_cnt)
  );

  phy_rx_sat_counter #(.MAX(LOCK_COUNT), .W(BC_W)) u_bc_counter (
    .clk_i (clk_f), .rst_ni(reset), .clr_i(bc_clr), .en_i(bc_en), .cnt_o(bc_cnt)
  );

  phy_rx_sat_counter #(.MAX(ERR_LIMIT), .W(ERR_W)) u_err_counter (
    .clk_i (clk_f), .rst_ni(reset), .clr_i(err_clr), .en_i(err_en), .cnt_o(err_cnt)
  );

  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    slip_req_d  = 1'b0;
    hunt_clr    = 1'b0;
    hunt_en     = 1'b0;
    settle_clr  = 1'b0;
    settle_en   = 1'b0;
    bc_clr      = 1'b0;
    bc_en       = 1'b0;
    err_clr     = 1'b0;
    err_en      = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (is_comma) begin
          bc_en   = 1'b1;
          state_d = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_LOCK;
        end else if (is_other) begin
          if (hunt_cnt == HUNT_LAST) begin
            hunt_clr   = 1'b1;
            slip_req_d = 1'b1;
            state_d    = ST_SLIP_WAIT;
          end else begin
            hunt_en = 1'b1;
          end
        end
      end

      ST_SLIP_WAIT: begin
        settle_en = 1'b1;
        if (settle_cnt == SETTLE_LAST) begin
          settle_clr = 1'b1;
          hunt_clr   = 1'b1;
          state_d    = ST_HUNT;
        end
      end

      ST_LOCK: begin
        if (is_comma) begin
          bc_en = 1'b1;
          if (bc_cnt == BC_LAST) begin
            state_d = ST_ACTIVE;
          end
        end else if (is_other) begin
          bc_clr  = 1'b1;
          state_d = ST_HUNT;
        end
      end

      ST_ACTIVE: begin
        if (is_comma) begin
          err_clr = 1'b1;
        end else if (data_in_valid && sym_err) begin
          if (err_cnt == ERR_LAST) begin
            err_clr = 1'b1;
            bc_clr  = 1'b1;
            state_d = ST_HUNT;
          end else begin
            err_en = 1'b1;
          end
        end else if (data_in_valid) begin
          valid_out_d = 1'b1;
          data_out_d  = data_in;
        end
      end

      default: begin
        hunt_clr   = 1'b1;
        settle_clr = 1'b1;
        bc_clr     = 1'b1;
        err_clr    = 1'b1;
        state_d    = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HUNT;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      slip_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      slip_req_q  <= slip_req_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign slip_req   = slip_req_q;
  assign active     = (state_q == ST_ACTIVE);
  assign bc_counter = 4'(bc_cnt);
  assign state_out  = state_q;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed and randomised checks of phy_rx_sync_ctrl against a behavioural
// model of the link-synchronisation rules.
module tb_phy_rx_sync_ctrl;

  localparam int LOCK_N    = 4;
  localparam int TIMEOUT_N = 16;
  localparam int SETTLE_N  = 8;
  localparam int ERR_N     = 3;

  logic       clk_f = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       sym_err = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       slip_req;
  logic [3:0] bc_counter;
  logic [2:0] state_out;

  phy_rx_sync_ctrl #(
    .COMMA       (8'hBC),
    .LOCK_COUNT  (LOCK_N),
    .SLIP_TIMEOUT(TIMEOUT_N),
    .SLIP_SETTLE (SETTLE_N),
    .ERR_LIMIT   (ERR_N)
  ) dut (
    .clk_f        (clk_f),
    .reset        (reset),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .sym_err      (sym_err),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .active       (active),
    .slip_req     (slip_req),
    .bc_counter   (bc_counter),
    .state_out    (state_out)
  );

  always #5 clk_f = ~clk_f;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0=hunting, 1=settling after slip, 2=locking, 3=synced
  int       m_mode, m_hunt, m_settle, m_commas, m_errs;
  int       m_dout;
  bit       m_vout, m_slip;
  int       fwd_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hunt = 0; m_settle = 0; m_commas = 0; m_errs = 0;
    m_dout = 0; m_vout = 0; m_slip = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit e);
    bit comma;
    comma  = v && !e && (d == 'hBC);
    m_vout = 0;
    m_slip = 0;
    if (m_mode == 0) begin
      if (comma) begin
        m_commas = 1;
        m_mode   = (m_commas >= LOCK_N) ? 3 : 2;
      end else if (v) begin
        m_hunt++;
        if (m_hunt >= TIMEOUT_N) begin
          m_hunt = 0; m_slip = 1; m_mode = 1; m_settle = 0;
        end
      end
    end else if (m_mode == 1) begin
      m_settle++;
      if (m_settle >= SETTLE_N) begin
        m_settle = 0; m_hunt = 0; m_mode = 0;
      end
    end else if (m_mode == 2) begin
      if (comma) begin
        m_commas++;
        if (m_commas >= LOCK_N) m_mode = 3;
      end else if (v) begin
        m_commas = 0; m_mode = 0;
      end
    end else begin
      if (comma) m_errs = 0;
      else if (v && e) begin
        m_errs++;
        if (m_errs >= ERR_N) begin
          m_errs = 0; m_commas = 0; m_mode = 0;
        end
      end else if (v) begin
        m_vout = 1; m_dout = d;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".data_out"},   data_out,   m_dout);
    chk({tag, ".valid_out"},  valid_out,  m_vout);
    chk({tag, ".active"},     active,     m_mode == 3);
    chk({tag, ".slip_req"},   slip_req,   m_slip);
    chk({tag, ".bc_counter"}, bc_counter, m_commas);
    chk({tag, ".state"},      state_out,  m_mode);
  endtask

  task automatic cycle(input string tag, input bit v, input logic [7:0] d, input bit e);
    data_in_valid = v;
    data_in       = d;
    sym_err       = e;
    @(posedge clk_f);
    model_step(v, d, e);
    #1;
    if (valid_out) fwd_q.push_back(data_out);
    check_outputs(tag);
  endtask

  // Reset is asserted between edges so the clear is seen to be asynchronous.
  task automatic async_reset(input string tag);
    data_in_valid = 1'b0;
    sym_err       = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(posedge clk_f);
    #2;
    reset = 1'b1;
  endtask

  task automatic lock_up(input string tag);
    for (int i = 0; i < LOCK_N; i++) cycle(tag, 1'b1, 8'hBC, 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    bit         rv, re;
    model_reset();
    #3;
    check_outputs("por");
    @(posedge clk_f);
    #2;
    reset = 1'b1;

    // 1: mid-stream reset, then lock and forward one byte
    cycle("t1.pre", 1'b1, 8'hBC, 1'b0);
    cycle("t1.pre", 1'b1, 8'h42, 1'b0);
    async_reset("t1.rst");
    lock_up("t1.lock");
    chk("t1.active_after_4th", active, 1'b1);
    chk("t1.bc_hold", bc_counter, LOCK_N);
    cycle("t1.data", 1'b1, 8'h11, 1'b0);
    chk("t1.dout", data_out, 8'h11);
    chk("t1.vout", valid_out, 1'b1);
    cycle("t1.idle", 1'b0, 8'h00, 1'b0);
    chk("t1.vout_drop", valid_out, 1'b0);

    // 2: hunt timeout, slip pulse, settle window ignores commas
    async_reset("t2.rst");
    for (int i = 0; i < TIMEOUT_N - 1; i++) cycle("t2.hunt", 1'b1, 8'h55, 1'b0);
    chk("t2.no_early_slip", slip_req, 1'b0);
    cycle("t2.last", 1'b1, 8'h55, 1'b0);
    chk("t2.slip", slip_req, 1'b1);
    for (int i = 0; i < SETTLE_N; i++) begin
      cycle("t2.settle", 1'b1, 8'hBC, 1'b0);
      chk("t2.slip_once", slip_req, 1'b0);
    end
    chk("t2.back_hunt", state_out, 3'd0);
    chk("t2.bc_zero", bc_counter, 4'd0);
    cycle("t2.resume", 1'b1, 8'hBC, 1'b0);
    chk("t2.resume_bc", bc_counter, 4'd1);

    // Erroneous comma counts as a hunt byte
    async_reset("t2b.rst");
    for (int i = 0; i < TIMEOUT_N; i++) cycle("t2b.errcomma", 1'b1, 8'hBC, 1'b1);
    chk("t2b.slip", slip_req, 1'b1);

    // 3: broken comma run restarts the lock count
    async_reset("t3.rst");
    cycle("t3", 1'b1, 8'hBC, 1'b0);
    cycle("t3", 1'b1, 8'hBC, 1'b0);
    cycle("t3.break", 1'b1, 8'h3C, 1'b0);
    chk("t3.bc_cleared", bc_counter, 4'd0);
    for (int i = 0; i < LOCK_N - 1; i++) begin
      cycle("t3.relock", 1'b1, 8'hBC, 1'b0);
      chk("t3.not_yet", active, 1'b0);
    end
    cycle("t3.final", 1'b1, 8'hBC, 1'b0);
    chk("t3.active", active, 1'b1);

    // 4: error counting, comma clears, third consecutive error drops sync
    cycle("t4", 1'b1, 8'hA0, 1'b1);
    cycle("t4", 1'b1, 8'hA1, 1'b1);
    cycle("t4.clr", 1'b1, 8'hBC, 1'b0);
    cycle("t4", 1'b1, 8'hA2, 1'b1);
    cycle("t4", 1'b1, 8'hA3, 1'b1);
    chk("t4.still_active", active, 1'b1);
    cycle("t4.drop", 1'b1, 8'hA4, 1'b1);
    chk("t4.active_low", active, 1'b0);
    chk("t4.hunt", state_out, 3'd0);
    chk("t4.no_vout", valid_out, 1'b0);

    // 5: gaps and comma fill between payload bytes
    async_reset("t5.rst");
    lock_up("t5.lock");
    fwd_q.delete();
    cycle("t5", 1'b0, 8'h77, 1'b0);
    cycle("t5", 1'b1, 8'h01, 1'b0);
    cycle("t5", 1'b1, 8'hBC, 1'b0);
    cycle("t5", 1'b0, 8'h99, 1'b0);
    cycle("t5", 1'b0, 8'h98, 1'b0);
    cycle("t5", 1'b1, 8'h02, 1'b0);
    cycle("t5", 1'b1, 8'hBC, 1'b0);
    cycle("t5", 1'b1, 8'hBC, 1'b0);
    cycle("t5", 1'b0, 8'h00, 1'b0);
    cycle("t5", 1'b1, 8'h03, 1'b0);
    cycle("t5", 1'b0, 8'h00, 1'b0);
    chk("t5.count", fwd_q.size(), 3);
    if (fwd_q.size() == 3) begin
      chk("t5.b0", fwd_q[0], 8'h01);
      chk("t5.b1", fwd_q[1], 8'h02);
      chk("t5.b2", fwd_q[2], 8'h03);
    end

    // 6: async reset while slip pulse is out / while settling / while active
    async_reset("t6.rst0");
    for (int i = 0; i < TIMEOUT_N; i++) cycle("t6.hunt", 1'b1, 8'h55, 1'b0);
    async_reset("t6.cut_slip");
    for (int i = 0; i < TIMEOUT_N + 3; i++) cycle("t6.hunt2", 1'b1, 8'h55, 1'b0);
    chk("t6.in_settle", state_out, 3'd1);
    async_reset("t6.settle");
    lock_up("t6.lock");
    cycle("t6.data", 1'b1, 8'h5A, 1'b0);
    async_reset("t6.active");
    cycle("t6.after", 1'b0, 8'h00, 1'b0);

    // Randomised traffic, comma-heavy so lock is reached regularly
    for (int i = 0; i < 4000; i++) begin
      rv = ($urandom_range(0, 99) < 85);
      re = ($urandom_range(0, 99) < 6);
      rb = ($urandom_range(0, 99) < 50) ? 8'hBC : 8'($urandom);
      if ($urandom_range(0, 999) == 0) async_reset("rnd.rst");
      else cycle("rnd", rv, rb, re);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_rx_sync_ctrl.md
Name: phy_rx_sync_ctrl

Overview:
Link-synchronisation controller for the PHY receive path. It sits behind the serial-to-parallel converter in the clk_f domain and inspects each deserialised byte. It runs a hunt/slip/lock state machine on comma (0xBC) bytes to achieve byte alignment, then gates received data through to the upper layer. It declares loss of sync on repeated symbol errors and restarts alignment.

Parameters:
COMMA, 8'hBC, alignment/idle symbol
LOCK_COUNT, 4, consecutive commas required to enter ACTIVE (1..15)
SLIP_TIMEOUT, 16, valid non-comma bytes in HUNT before requesting a bit slip
SLIP_SETTLE, 8, clk_f cycles to wait after a slip request before hunting again
ERR_LIMIT, 3, symbol errors in ACTIVE (without intervening error-free comma) that drop sync

Ports:
clk_f  input  1  byte clock, sole clock, rising edge
reset  input  1  asynchronous, active-low; all state cleared while low
data_in  input  8  byte from serial-to-parallel converter
data_in_valid  input  1  data_in holds a new byte this cycle
sym_err  input  1  data_in byte flagged invalid (qualified by data_in_valid)
data_out  output  8  registered payload byte
valid_out  output  1  data_out is payload this cycle
active  output  1  link synchronised (state ACTIVE)
slip_req  output  1  one-cycle pulse: deserialiser shifts alignment by one bit
bc_counter  output  4  consecutive commas counted toward lock
state_out  output  3  encoded FSM state, for debug

Behaviour:
- Reset (reset low, async): state=HUNT; data_out=0, valid_out=0, active=0, slip_req=0, bc_counter=0; internal timers 0.
- Cycles with data_in_valid=0: no state, counter or timer change except the SLIP_WAIT settle timer, which counts every cycle. valid_out=0.
- A byte "is comma" only when data_in==COMMA and sym_err=0.
- HUNT:
  - comma: bc_counter=1, go LOCK.
  - any other valid byte: increment the hunt timer.
  - When the hunt timer reaches SLIP_TIMEOUT: slip_req=1 for exactly one cycle, hunt timer cleared, go SLIP_WAIT.
- SLIP_WAIT:
  - Ignores all input bytes.
  - After SLIP_SETTLE cycles, go HUNT with hunt timer=0.
- LOCK:
  - comma: bc_counter+1.
  - If bc_counter+1 == LOCK_COUNT: go ACTIVE; active=1 from the next cycle.
  - Non-comma valid byte, including sym_err: bc_counter=0, go HUNT. This is not counted toward SLIP_TIMEOUT.
- ACTIVE:
  - bc_counter holds LOCK_COUNT.
  - Each valid byte is registered to data_out with 1-cycle latency.
  - valid_out=1 iff the byte is not comma and sym_err=0. Commas are idle fill and are never forwarded.
  - sym_err increments the error counter. A comma clears it.
  - When the error counter reaches ERR_LIMIT: go HUNT, active=0 from the next cycle, bc_counter=0, no valid_out for that byte.
- LOCK_COUNT=1: the first comma in HUNT goes directly to ACTIVE.
- COMMA with sym_err in HUNT counts as a non-comma byte for the timer.
- data_out holds its last value when valid_out=0.
- Counters saturate and never wrap. Widths are $clog2 of their limit+1.
- Reset asserted mid-operation (any state): immediate return to reset values. A slip_req in flight is cut.
- State encoding: HUNT=0, SLIP_WAIT=1, LOCK=2, ACTIVE=3. Other codes recover to HUNT.

Decomposition:
- Shared package phy_rx_pkg:
  - state enum/localparams (HUNT, SLIP_WAIT, LOCK, ACTIVE)
  - COMMA default 8'hBC
  - default LOCK_COUNT
- One natural sub-module: phy_rx_sat_counter, a parameterised saturating counter with clear and enable. It is instantiated for the hunt timer, settle timer, bc_counter and error counter.
- The FSM and output registers stay in the top module.

Test Plan:
1. Reset low mid-stream, then release; feed BC,BC,BC,BC then 0x11 -> bc_counter 1..4; active=1 the cycle after the 4th BC; data_out=0x11 with valid_out=1 one cycle after the 0x11 input.
2. In HUNT feed 16 bytes of 0x55 -> slip_req pulses once after the 16th byte. The next 8 cycles of input (BC included) are ignored, then HUNT resumes with bc_counter=0.
3. Feed BC,BC,0x3C,BC,BC,BC,BC -> bc_counter resets to 0 at 0x3C; ACTIVE is reached only after the final 4 BCs.
4. In ACTIVE send 0xA0(sym_err),0xA1(sym_err),BC,0xA2(sym_err),0xA3(sym_err),0xA4(sym_err) -> BC clears the error count; the 3rd consecutive error drops active to 0 and the state returns to HUNT; erroneous bytes never produce valid_out.
5. In ACTIVE interleave data_in_valid=0 cycles and BC fill among 0x01,0x02,0x03 -> valid_out is high exactly 3 times, with data_out 0x01,0x02,0x03 in order; BC is never forwarded.
6. Assert reset during SLIP_WAIT and during ACTIVE -> all outputs are 0 in the same cycle (async); on release the state is HUNT.
